// File: rtl/ddfs_pkg.sv
// Shared types and constants for the DDFS block family.
// Sweeper state, configuration bundle and default widths.
package ddfs_pkg;

    localparam int DDFS_FREQ_WIDTH  = 32;
    localparam int DDFS_DWELL_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } sweep_state_t;

    typedef struct packed {
        logic                        mode;
        logic [DDFS_FREQ_WIDTH-1:0]  start;
        logic [DDFS_FREQ_WIDTH-1:0]  stop;
        logic [DDFS_FREQ_WIDTH-1:0]  step;
        logic [DDFS_DWELL_WIDTH-1:0] dwell;
    } sweep_cfg_t;

endpackage

// File: rtl/ddfs_dwell_timer.sv
// Loadable down-counter timing how long each sweep word is held.
// Saturates at zero; zero flag tells the sweeper to step.
module ddfs_dwell_timer
    import ddfs_pkg::*;
#(
    parameter int DWELL_WIDTH = DDFS_DWELL_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [DWELL_WIDTH-1:0] value,
    input  logic                   enable,
    output logic                   zero
);

    logic [DWELL_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ddfs_freq_sweeper.sv
// Linear frequency sweep source feeding the DDFS frequency word.
// Single-shot or continuous, each word held a programmable dwell.
module ddfs_freq_sweeper
    import ddfs_pkg::*;
#(
    parameter int FREQ_WIDTH  = DDFS_FREQ_WIDTH,
    parameter int DWELL_WIDTH = DDFS_DWELL_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic                   i_mode,
    input  logic [FREQ_WIDTH-1:0]  i_start_freq,
    input  logic [FREQ_WIDTH-1:0]  i_stop_freq,
    input  logic [FREQ_WIDTH-1:0]  i_step,
    input  logic [DWELL_WIDTH-1:0] i_dwell,
    output logic [FREQ_WIDTH-1:0]  o_freq_control,
    output logic                   o_freq_valid,
    output logic                   o_busy,
    output logic                   o_done
);

    sweep_state_t           state, state_nxt;
    sweep_cfg_t             cfg, cfg_nxt;
    logic [FREQ_WIDTH-1:0]  freq, freq_nxt;
    logic                   valid, valid_nxt;
    logic                   busy, busy_nxt;
    logic                   done, done_nxt;
    logic                   tmr_load, tmr_enable, tmr_zero;
    logic [DWELL_WIDTH-1:0] tmr_value, dwell_eff;
    logic [FREQ_WIDTH:0]    sum;
    logic                   in_range;

    ddfs_dwell_timer #(
        .DWELL_WIDTH(DWELL_WIDTH)
    ) u_timer (
        .clk   (i_clk),
        .rst_n (i_rst),
        .load  (tmr_load),
        .value (tmr_value),
        .enable(tmr_enable),
        .zero  (tmr_zero)
    );

    assign dwell_eff = (i_dwell == '0) ? DWELL_WIDTH'(1) : i_dwell;
    // Carry-out counts as past the stop word, so the sweep never wraps.
    assign sum      = {1'b0, freq} + {1'b0, cfg.step};
    assign in_range = !sum[FREQ_WIDTH] &&
                      (sum[FREQ_WIDTH-1:0] <= cfg.stop);

    always_comb begin
        state_nxt  = state;
        cfg_nxt    = cfg;
        freq_nxt   = freq;
        valid_nxt  = 1'b0;
        busy_nxt   = busy;
        done_nxt   = 1'b0;
        tmr_load   = 1'b0;
        tmr_enable = 1'b0;
        tmr_value  = cfg.dwell - DWELL_WIDTH'(1);
        unique case (state)
            IDLE: begin
                if (i_start && !i_abort) begin
                    cfg_nxt.mode  = i_mode;
                    cfg_nxt.start = i_start_freq;
                    cfg_nxt.stop  = i_stop_freq;
                    cfg_nxt.step  = i_step;
                    cfg_nxt.dwell = dwell_eff;
                    state_nxt     = SWEEP;
                    freq_nxt      = i_start_freq;
                    valid_nxt     = 1'b1;
                    busy_nxt      = 1'b1;
                    tmr_load      = 1'b1;
                    tmr_value     = dwell_eff - DWELL_WIDTH'(1);
                end
            end
            SWEEP: begin
                if (i_abort) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                end else if (!tmr_zero) begin
                    tmr_enable = 1'b1;
                end else if (in_range) begin
                    freq_nxt  = sum[FREQ_WIDTH-1:0];
                    valid_nxt = 1'b1;
                    tmr_load  = 1'b1;
                end else if (cfg.mode) begin
                    freq_nxt  = cfg.start;
                    valid_nxt = 1'b1;
                    tmr_load  = 1'b1;
                end else begin
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= IDLE;
            cfg   <= '0;
            freq  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cfg   <= cfg_nxt;
            freq  <= freq_nxt;
            valid <= valid_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    assign o_freq_control = freq;
    assign o_freq_valid   = valid;
    assign o_busy         = busy;
    assign o_done         = done;

endmodule

// File: tb/tb_ddfs_freq_sweeper.sv
// Bench for ddfs_freq_sweeper: trace-based sweep model plus
// directed scenarios with hand-computed expectations.
module tb_ddfs_freq_sweeper;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        i_mode = 1'b0;
    logic [31:0] i_start_freq = '0;
    logic [31:0] i_stop_freq = '0;
    logic [31:0] i_step = '0;
    logic [15:0] i_dwell = '0;
    logic [31:0] o_freq_control;
    logic        o_freq_valid;
    logic        o_busy;
    logic        o_done;

    ddfs_freq_sweeper dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_abort       (i_abort),
        .i_mode        (i_mode),
        .i_start_freq  (i_start_freq),
        .i_stop_freq   (i_stop_freq),
        .i_step        (i_step),
        .i_dwell       (i_dwell),
        .o_freq_control(o_freq_control),
        .o_freq_valid  (o_freq_valid),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] f;
        logic        v;
        logic        b;
        logic        d;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_chk = 0;
    int   n_fail = 0;
    int   vcount;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h, required 0x%08h",
                     name, $time, act, exp);
        end
    endtask

    // Expand a whole sweep into its cycle-by-cycle output trace.
    task automatic gen_trace(input logic mode, input logic [31:0] s,
                             input logic [31:0] stop,
                             input logic [31:0] step,
                             input logic [15:0] dw);
        int          d;
        int          n;
        logic [31:0] w;
        logic [32:0] nx;
        d = (dw == 16'd0) ? 1 : int'(dw);
        w = s;
        n = 0;
        while (n < 400) begin
            for (int k = 0; k < d; k++) begin
                q.push_back('{w, (k == 0), 1'b1, 1'b0});
                n++;
            end
            nx = {1'b0, w} + {1'b0, step};
            if (!nx[32] && nx[31:0] <= stop) begin
                w = nx[31:0];
            end else if (mode) begin
                w = s;
            end else begin
                q.push_back('{w, 1'b0, 1'b0, 1'b1});
                break;
            end
        end
    endtask

    // One clock: update model from inputs seen at the edge, compare,
    // then return at the falling edge for the next stimulus.
    task automatic cyc();
        @(posedge i_clk);
        if (!i_rst) begin
            q.delete();
            cur = '{32'd0, 1'b0, 1'b0, 1'b0};
        end else if (cur.b && i_abort) begin
            q.delete();
            cur = '{cur.f, 1'b0, 1'b0, 1'b0};
        end else begin
            if (!cur.b && !cur.d && i_start && !i_abort)
                gen_trace(i_mode, i_start_freq, i_stop_freq,
                          i_step, i_dwell);
            if (q.size() > 0) cur = q.pop_front();
            else cur = '{cur.f, 1'b0, 1'b0, 1'b0};
        end
        #1;
        chk("model_freq", o_freq_control, cur.f);
        chk("model_valid", 32'(o_freq_valid), 32'(cur.v));
        chk("model_busy", 32'(o_busy), 32'(cur.b));
        chk("model_done", 32'(o_done), 32'(cur.d));
        @(negedge i_clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic go(input logic mode, input logic [31:0] s,
                      input logic [31:0] stop, input logic [31:0] step,
                      input logic [15:0] dw);
        i_mode       = mode;
        i_start_freq = s;
        i_stop_freq  = stop;
        i_step       = step;
        i_dwell      = dw;
        i_start      = 1'b1;
        cyc();
        i_start      = 1'b0;
    endtask

    initial begin
        cur = '{32'd0, 1'b0, 1'b0, 1'b0};
        run(3);
        chk("rst_freq", o_freq_control, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        i_rst = 1'b1;
        run(2);

        // Scenario 1: single five-word sweep, dwell 4
        go(1'b0, 32'h000F_FFFF, 32'h004F_FFFF, 32'h0010_0000, 16'd4);
        vcount = 0;
        for (int c = 1; c <= 25; c++) begin
            if (c > 1) cyc();
            if (o_freq_valid) vcount++;
            if (c == 1) chk("s1_first", o_freq_control, 32'h000F_FFFF);
            if (c == 4) chk("s1_hold", o_freq_control, 32'h000F_FFFF);
            if (c == 5) chk("s1_second", o_freq_control, 32'h001F_FFFF);
            if (c == 20) chk("s1_busy20", 32'(o_busy), 32'd1);
            if (c == 21) chk("s1_done21", 32'(o_done), 32'd1);
            if (c == 21) chk("s1_nbusy21", 32'(o_busy), 32'd0);
            if (c == 22) chk("s1_done22", 32'(o_done), 32'd0);
        end
        chk("s1_pulses", 32'(vcount), 32'd5);
        chk("s1_final", o_freq_control, 32'h004F_FFFF);

        // Scenario 2: carry-out ends the sweep after one word
        go(1'b0, 32'hFFF0_0000, 32'hFFFF_FFFF, 32'h0020_0000, 16'd2);
        run(2);
        chk("s2_done", 32'(o_done), 32'd1);
        chk("s2_nowrap", o_freq_control, 32'hFFF0_0000);
        run(3);

        // Scenario 3: continuous, dwell 1, then abort
        go(1'b1, 32'h100, 32'h300, 32'h100, 16'd1);
        for (int c = 2; c <= 10; c++) begin
            cyc();
            if (c == 3) chk("s3_third", o_freq_control, 32'h300);
            if (c == 4) chk("s3_wrap", o_freq_control, 32'h100);
            if (c == 4) chk("s3_valid", 32'(o_freq_valid), 32'd1);
        end
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        chk("s3_abort_busy", 32'(o_busy), 32'd0);
        chk("s3_abort_hold", o_freq_control, 32'h100);
        run(3);

        // Scenario 4: abort during the third word, then restart
        go(1'b0, 32'h000F_FFFF, 32'h004F_FFFF, 32'h0010_0000, 16'd4);
        run(9);
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        chk("s4_hold", o_freq_control, 32'h002F_FFFF);
        chk("s4_busy", 32'(o_busy), 32'd0);
        run(4);
        chk("s4_nodone", 32'(o_done), 32'd0);
        go(1'b0, 32'h40, 32'h80, 32'h20, 16'd1);
        chk("s4_restart", 32'(o_busy), 32'd1);
        run(5);

        // Start and abort together while idle: start ignored
        i_start = 1'b1;
        i_abort = 1'b1;
        cyc();
        i_start = 1'b0;
        i_abort = 1'b0;
        chk("idle_sa_busy", 32'(o_busy), 32'd0);
        run(2);

        // Scenario 5: asynchronous reset between edges
        go(1'b0, 32'h000F_FFFF, 32'h004F_FFFF, 32'h0010_0000, 16'd4);
        run(5);
        #2 i_rst = 1'b0;
        #1;
        chk("s5_freq", o_freq_control, 32'd0);
        chk("s5_busy", 32'(o_busy), 32'd0);
        chk("s5_valid", 32'(o_freq_valid), 32'd0);
        chk("s5_done", 32'(o_done), 32'd0);
        run(2);
        i_rst = 1'b1;
        run(4);
        chk("s5_idle", 32'(o_busy), 32'd0);

        // Scenario 6: dwell 0, start pulses mid-sweep and in DONE
        go(1'b0, 32'h10, 32'h50, 32'h10, 16'd0);
        cyc();
        i_start      = 1'b1;
        i_start_freq = 32'h999;
        i_stop_freq  = 32'hFFFF;
        cyc();
        i_start      = 1'b0;
        chk("s6_third", o_freq_control, 32'h30);
        run(3);
        chk("s6_done", 32'(o_done), 32'd1);
        chk("s6_last", o_freq_control, 32'h50);
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        chk("s6_done_start", 32'(o_busy), 32'd0);
        run(2);

        // start > stop: one dwell then done
        go(1'b0, 32'h500, 32'h100, 32'h1, 16'd3);
        run(3);
        chk("gt_done", 32'(o_done), 32'd1);
        chk("gt_word", o_freq_control, 32'h500);
        run(2);

        // step 0: same word re-emitted every dwell until abort
        go(1'b0, 32'h40, 32'h80, 32'h0, 16'd2);
        run(4);
        chk("z_valid", 32'(o_freq_valid), 32'd1);
        chk("z_word", o_freq_control, 32'h40);
        run(7);
        i_abort = 1'b1;
        cyc();
        i_abort = 1'b0;
        run(3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
